// File: rtl/receive_state_machine.sv
// -----------------------------------------------------------------------------
// receive_state_machine
// UART receive sequencer for the eUSCI serial block. It detects a start bit on
// Rx and samples one bit per rising edge of the baud strobe BITCLK. It then
// assembles a 7- or 8-bit character (LSB- or MSB-first, optional odd/even
// parity, 1 or 2 stop bits). At the end of the frame it reports the character,
// the error/break flags and a request to set RxIFG.
//
// Ports
//   MCLK      in   system clock, all state updates on its rising edge
//   reset     in   asynchronous active-high reset (SWRST)
//   BITCLK    in   baud-rate square wave, edge-detected in the MCLK domain
//   wUCPEN    in   parity enable
//   wUCPAR    in   parity select (0 = odd, 1 = even)
//   wUCMSB    in   1 = MSB first
//   wUC7BIT   in   1 = 7-bit characters
//   wUCSPB    in   1 = two stop bits
//   wUCRXEIE  in   1 = erroneous characters are still loaded
//   Rx        in   serial line (idles high)
//   RxIFG     in   current receive interrupt flag (overrun detection)
//   RxBEN     out  baud-generator enable
//   rUCPE     out  parity error
//   rUCFE     out  framing error
//   rUCOE     out  overrun error
//   rUCBRK    out  break detected
//   rSetRxIFG out  request to set RxIFG
//   RxData    out  received character (bit 7 = 0 in 7-bit mode)
//   RxBusy    out  frame in progress
// -----------------------------------------------------------------------------
module receive_state_machine (
    input  logic       MCLK,
    input  logic       reset,
    input  logic       BITCLK,
    input  logic       wUCPEN,
    input  logic       wUCPAR,
    input  logic       wUCMSB,
    input  logic       wUC7BIT,
    input  logic       wUCSPB,
    input  logic       wUCRXEIE,
    input  logic       Rx,
    input  logic       RxIFG,
    output logic       RxBEN,
    output logic       rUCPE,
    output logic       rUCFE,
    output logic       rUCOE,
    output logic       rUCBRK,
    output logic       rSetRxIFG,
    output logic [7:0] RxData,
    output logic       RxBusy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DATA   = 3'd1,
        S_PARITY = 3'd2,
        S_STOP1  = 3'd3,
        S_STOP2  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        bitclk_q;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        par_q, par_d;          // running XOR of received data bits
    logic        frame_pe_q, frame_pe_d;
    logic        frame_fe_q, frame_fe_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        pe_q, pe_d;
    logic        fe_q, fe_d;
    logic        oe_q, oe_d;
    logic        brk_q, brk_d;
    logic        set_ifg_q, set_ifg_d;

    logic        bit_edge_s;
    logic [2:0]  last_idx_s;
    logic [2:0]  data_pos_s;
    logic        finish_s;
    logic        err_s;

    assign bit_edge_s = BITCLK & ~bitclk_q;
    assign last_idx_s = wUC7BIT ? 3'd6 : 3'd7;
    // MSB-first fills from the top data bit downwards.
    assign data_pos_s = wUCMSB ? (last_idx_s - cnt_q) : cnt_q;

    // Next-state, shift register and end-of-frame reporting logic.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        par_d      = par_q;
        frame_pe_d = frame_pe_q;
        frame_fe_d = frame_fe_q;
        rx_data_d  = rx_data_q;
        pe_d       = pe_q;
        fe_d       = fe_q;
        oe_d       = oe_q;
        brk_d      = brk_q;
        set_ifg_d  = set_ifg_q;
        finish_s   = 1'b0;
        err_s      = 1'b0;

        if (bit_edge_s) begin
            case (state_q)
                S_IDLE: begin
                    if (!Rx) begin
                        state_d    = S_DATA;
                        shift_d    = 8'h00;
                        cnt_d      = 3'd0;
                        par_d      = 1'b0;
                        frame_pe_d = 1'b0;
                        frame_fe_d = 1'b0;
                        pe_d       = 1'b0;
                        fe_d       = 1'b0;
                        oe_d       = 1'b0;
                        brk_d      = 1'b0;
                        set_ifg_d  = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_DATA: begin
                    shift_d[data_pos_s] = Rx;
                    par_d = par_q ^ Rx;
                    if (cnt_q == last_idx_s) begin
                        state_d = wUCPEN ? S_PARITY : S_STOP1;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                S_PARITY: begin
                    // Odd parity (PAR=0) fails on an even total, even parity on an odd one.
                    frame_pe_d = ~(par_q ^ Rx ^ wUCPAR);
                    state_d    = S_STOP1;
                end
                S_STOP1: begin
                    frame_fe_d = ~Rx;
                    if (wUCSPB) begin
                        state_d = S_STOP2;
                    end else begin
                        finish_s = 1'b1;
                    end
                end
                S_STOP2: begin
                    frame_fe_d = frame_fe_q | ~Rx;
                    finish_s   = 1'b1;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        // Report in the final stop-sample cycle; break alone never blocks the load.
        if (finish_s) begin
            state_d = S_IDLE;
            err_s   = frame_fe_d | frame_pe_q | RxIFG;
            pe_d    = frame_pe_q;
            fe_d    = frame_fe_d;
            oe_d    = RxIFG;
            brk_d   = (shift_q == 8'h00);
            if (!err_s || wUCRXEIE) begin
                rx_data_d = shift_q;
                set_ifg_d = 1'b1;
            end else begin
                set_ifg_d = 1'b0;
            end
        end else begin
            err_s = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            bitclk_q   <= 1'b0;
            shift_q    <= 8'h00;
            cnt_q      <= 3'd0;
            par_q      <= 1'b0;
            frame_pe_q <= 1'b0;
            frame_fe_q <= 1'b0;
            rx_data_q  <= 8'h00;
            pe_q       <= 1'b0;
            fe_q       <= 1'b0;
            oe_q       <= 1'b0;
            brk_q      <= 1'b0;
            set_ifg_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitclk_q   <= BITCLK;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            par_q      <= par_d;
            frame_pe_q <= frame_pe_d;
            frame_fe_q <= frame_fe_d;
            rx_data_q  <= rx_data_d;
            pe_q       <= pe_d;
            fe_q       <= fe_d;
            oe_q       <= oe_d;
            brk_q      <= brk_d;
            set_ifg_q  <= set_ifg_d;
        end
    end

    assign RxBusy    = (state_q != S_IDLE);
    // Request the baud generator as soon as the line falls.
    assign RxBEN     = RxBusy | ~Rx;
    assign RxData    = rx_data_q;
    assign rUCPE     = pe_q;
    assign rUCFE     = fe_q;
    assign rUCOE     = oe_q;
    assign rUCBRK    = brk_q;
    assign rSetRxIFG = set_ifg_q;

endmodule

// File: tb/tb_receive_state_machine.sv
// -----------------------------------------------------------------------------
// tb_receive_state_machine
// Directed bench for receive_state_machine: serialises hand-picked frames for
// several line formats and compares the reported character, flags
// {FE,OE,PE,BRK} and rSetRxIFG against hand-computed values.
// -----------------------------------------------------------------------------
module tb_receive_state_machine;

    logic       MCLK;
    logic       reset;
    logic       BITCLK;
    logic       wUCPEN, wUCPAR, wUCMSB, wUC7BIT, wUCSPB, wUCRXEIE;
    logic       Rx;
    logic       RxIFG;
    logic       RxBEN, rUCPE, rUCFE, rUCOE, rUCBRK, rSetRxIFG, RxBusy;
    logic [7:0] RxData;

    int vectors;
    int miscompares;

    receive_state_machine dut (
        .MCLK      (MCLK),
        .reset     (reset),
        .BITCLK    (BITCLK),
        .wUCPEN    (wUCPEN),
        .wUCPAR    (wUCPAR),
        .wUCMSB    (wUCMSB),
        .wUC7BIT   (wUC7BIT),
        .wUCSPB    (wUCSPB),
        .wUCRXEIE  (wUCRXEIE),
        .Rx        (Rx),
        .RxIFG     (RxIFG),
        .RxBEN     (RxBEN),
        .rUCPE     (rUCPE),
        .rUCFE     (rUCFE),
        .rUCOE     (rUCOE),
        .rUCBRK    (rUCBRK),
        .rSetRxIFG (rSetRxIFG),
        .RxData    (RxData),
        .RxBusy    (RxBusy)
    );

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One bit time: line changes while BITCLK is low, then BITCLK rises.
    task automatic send_bit(input logic b);
        @(negedge MCLK);
        Rx = b;
        repeat (2) @(negedge MCLK);
        BITCLK = 1'b1;
        repeat (4) @(negedge MCLK);
        BITCLK = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s1, input logic s2);
        int nbits;
        nbits = wUC7BIT ? 7 : 8;
        send_bit(1'b0);
        for (int i = 0; i < nbits; i++) begin
            send_bit(wUCMSB ? d[nbits - 1 - i] : d[i]);
        end
        if (wUCPEN) send_bit(p);
        send_bit(s1);
        if (wUCSPB) send_bit(s2);
        send_bit(1'b1);
    endtask

    task automatic frame_chk(input string tag, input logic [7:0] exp_data,
                             input logic exp_set, input logic [3:0] exp_flags);
        chk({tag, ".data"}, RxData, exp_data);
        chk({tag, ".set"}, {7'd0, rSetRxIFG}, {7'd0, exp_set});
        chk({tag, ".flags"}, {4'd0, rUCFE, rUCOE, rUCPE, rUCBRK}, {4'd0, exp_flags});
        chk({tag, ".busy"}, {7'd0, RxBusy}, 8'h00);
    endtask

    task automatic cfg(input logic pen, input logic par, input logic msb,
                       input logic b7, input logic spb, input logic eie);
        @(negedge MCLK);
        wUCPEN = pen; wUCPAR = par; wUCMSB = msb;
        wUC7BIT = b7; wUCSPB = spb; wUCRXEIE = eie;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b1;
        BITCLK = 1'b0;
        Rx = 1'b1;
        RxIFG = 1'b0;
        wUCPEN = 1'b0; wUCPAR = 1'b0; wUCMSB = 1'b0;
        wUC7BIT = 1'b0; wUCSPB = 1'b0; wUCRXEIE = 1'b0;
        repeat (3) @(negedge MCLK);

        // Reset state
        frame_chk("rst", 8'h00, 1'b0, 4'b0000);
        chk("rst.ben_idle", {7'd0, RxBEN}, 8'h00);
        Rx = 1'b0;
        #1;
        chk("rst.ben_low", {7'd0, RxBEN}, 8'h01);
        Rx = 1'b1;
        @(negedge MCLK);
        reset = 1'b0;
        send_bit(1'b1);

        // 8N1 LSB-first, RXEIE=0
        cfg(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
        frame_chk("8N1.a5", 8'hA5, 1'b1, 4'b0000);
        send_frame(8'h3E, 1'b0, 1'b0, 1'b1);
        frame_chk("8N1.fe", 8'hA5, 1'b0, 4'b1000);
        RxIFG = 1'b1;
        send_frame(8'h6C, 1'b0, 1'b1, 1'b1);
        frame_chk("8N1.oe", 8'hA5, 1'b0, 4'b0100);
        RxIFG = 1'b0;
        send_frame(8'h00, 1'b0, 1'b1, 1'b1);
        frame_chk("8N1.brk", 8'h00, 1'b1, 4'b0001);

        // 8O2 LSB-first, RXEIE=1
        cfg(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        send_frame(8'h55, 1'b1, 1'b1, 1'b1);
        frame_chk("8O2.55", 8'h55, 1'b1, 4'b0000);
        send_frame(8'h3E, 1'b0, 1'b0, 1'b1);
        frame_chk("8O2.fe1", 8'h3E, 1'b1, 4'b1000);
        send_frame(8'h00, 1'b1, 1'b1, 1'b0);
        frame_chk("8O2.fe2brk", 8'h00, 1'b1, 4'b1001);
        send_frame(8'hA4, 1'b1, 1'b1, 1'b1);
        frame_chk("8O2.pe", 8'hA4, 1'b1, 4'b0010);
        RxIFG = 1'b1;
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
        frame_chk("8O2.oepe", 8'hA5, 1'b1, 4'b0110);
        RxIFG = 1'b0;

        // 8E1 MSB-first, RXEIE=0
        cfg(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(8'h34, 1'b1, 1'b1, 1'b1);
        frame_chk("8E1.34", 8'h34, 1'b1, 4'b0000);
        send_frame(8'h00, 1'b1, 1'b1, 1'b1);
        frame_chk("8E1.pebrk", 8'h34, 1'b0, 4'b0011);

        // 8N2 MSB-first, RXEIE=1
        cfg(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        send_frame(8'h1F, 1'b0, 1'b1, 1'b1);
        frame_chk("8N2.1f", 8'h1F, 1'b1, 4'b0000);
        send_frame(8'h00, 1'b0, 1'b0, 1'b1);
        frame_chk("8N2.fe1brk", 8'h00, 1'b1, 4'b1001);
        send_frame(8'hFF, 1'b0, 1'b1, 1'b0);
        frame_chk("8N2.fe2", 8'hFF, 1'b1, 4'b1000);

        // 7N1 LSB-first, RXEIE=0
        cfg(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b1);
        frame_chk("7N1.5a", 8'h5A, 1'b1, 4'b0000);
        send_frame(8'h11, 1'b0, 1'b0, 1'b1);
        frame_chk("7N1.fe", 8'h5A, 1'b0, 4'b1000);
        RxIFG = 1'b1;
        send_frame(8'h22, 1'b0, 1'b1, 1'b1);
        frame_chk("7N1.oe", 8'h5A, 1'b0, 4'b0100);
        RxIFG = 1'b0;
        send_frame(8'h00, 1'b0, 1'b1, 1'b1);
        frame_chk("7N1.brk", 8'h00, 1'b1, 4'b0001);

        // 7O2 MSB-first, RXEIE=1
        cfg(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        send_frame(8'h35, 1'b1, 1'b1, 1'b1);
        frame_chk("7O2.35", 8'h35, 1'b1, 4'b0000);
        send_frame(8'h5E, 1'b0, 1'b0, 1'b1);
        frame_chk("7O2.fe1", 8'h5E, 1'b1, 4'b1000);
        send_frame(8'h12, 1'b1, 1'b1, 1'b0);
        frame_chk("7O2.fe2", 8'h12, 1'b1, 4'b1000);
        send_frame(8'h00, 1'b0, 1'b1, 1'b1);
        frame_chk("7O2.pebrk", 8'h00, 1'b1, 4'b0011);

        // Reset mid-frame, then a clean 8N1 frame
        cfg(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        chk("mid.busy", {7'd0, RxBusy}, 8'h01);
        @(negedge MCLK);
        reset = 1'b1;
        #1;
        frame_chk("mid.rst", 8'h00, 1'b0, 4'b0000);
        @(negedge MCLK);
        reset = 1'b0;
        Rx = 1'b1;
        send_bit(1'b1);
        send_frame(8'hC3, 1'b0, 1'b1, 1'b1);
        frame_chk("post.c3", 8'hC3, 1'b1, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
